traffic_light_ctrl_actuated: RTL and testbench

Parametrised, demand-actuated two-road intersection controller; successor to the fixed-cycle 4-state traffic-light FSM. Adds configurable phase durations, an all-red clearance interval, vehicle-sensor and pedestrian-request actuation with min/max green, and a flashing fail-safe mode. Drives the light outputs directly from the top level of the intersection design.

---
 rtl/traffic_light_ctrl_actuated_pkg.sv | 20 ++
 rtl/traffic_light_ctrl_actuated_if.sv | 25 ++
 rtl/traffic_light_ctrl_actuated_phase_timer.sv | 37 +++
 rtl/traffic_light_ctrl_actuated.sv | 145 ++++++++++++++
 tb/tb_traffic_light_ctrl_actuated.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_ctrl_actuated_pkg.sv
// Shared definitions for the actuated intersection controller: controller
// state encoding and the {R,Y,G} lamp encodings driven onto both roads.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN   = 3'd0,
    ST_MAIN_YELLOW  = 3'd1,
    ST_ALL_RED_A    = 3'd2,
    ST_CROSS_GREEN  = 3'd3,
    ST_CROSS_YELLOW = 3'd4,
    ST_ALL_RED_B    = 3'd5,
    ST_FLASH        = 3'd6
  } state_e;

  localparam logic [2:0] LIGHT_R   = 3'b100;
  localparam logic [2:0] LIGHT_Y   = 3'b010;
  localparam logic [2:0] LIGHT_G   = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

endpackage

// File: rtl/traffic_light_ctrl_actuated_if.sv
// Signal bundle between the intersection (sensors, button, lamps) and the
// controller. The controller uses the slave view; the environment drives
// the inputs through the master view.
interface traffic_light_ctrl_actuated_if;

  logic       cross_sensor;
  logic       ped_req;
  logic       flash_mode;
  logic [2:0] main_light;
  logic [2:0] cross_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output cross_sensor, ped_req, flash_mode,
    input  main_light, cross_light, walk, ped_pending, phase
  );

  modport slave (
    input  cross_sensor, ped_req, flash_mode,
    output main_light, cross_light, walk, ped_pending, phase
  );

endinterface

// File: rtl/traffic_light_ctrl_actuated_phase_timer.sv
// Elapsed-cycle counter for the current phase. Cleared on every state
// change, otherwise counts up once per cycle and sticks at all-ones so a
// long-held main green never wraps back below its minimum.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  output logic [TW-1:0] elapsed
);

  logic [TW-1:0] elapsed_q;
  logic [TW-1:0] elapsed_d;

  // Next count: clear wins, then saturating increment.
  always_comb begin
    elapsed_d = elapsed_q;
    if (clear) begin
      elapsed_d = '0;
    end else if (elapsed_q != '1) begin
      elapsed_d = elapsed_q + TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed = elapsed_q;

endmodule

// File: rtl/traffic_light_ctrl_actuated.sv
// Demand-actuated two-road intersection controller. Main road rests in
// green until a cross vehicle, pedestrian or flash request arrives; cross
// green is bounded by min/max times; all phase changes pass through yellow
// and an all-red clearance, which is also the only way in or out of the
// flashing fail-safe mode.
module traffic_light_ctrl_actuated
  import traffic_pkg::*;
#(
  parameter int TW              = 8,
  parameter int MAIN_MIN_GREEN  = 8,
  parameter int CROSS_MIN_GREEN = 4,
  parameter int CROSS_MAX_GREEN = 10,
  parameter int YELLOW_TIME     = 3,
  parameter int ALL_RED_TIME    = 2,
  parameter int FLASH_HALF      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  traffic_light_ctrl_actuated_if.slave  bus
);

  // Last elapsed value of each timed interval, in counter width.
  localparam logic [TW-1:0] MAIN_MIN_LAST  = TW'(MAIN_MIN_GREEN - 1);
  localparam logic [TW-1:0] CROSS_MIN_LAST = TW'(CROSS_MIN_GREEN - 1);
  localparam logic [TW-1:0] CROSS_MAX_LAST = TW'(CROSS_MAX_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LAST    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ALL_RED_LAST   = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] FLASH_LAST     = TW'(FLASH_HALF - 1);

  state_e        state_q, state_d;
  logic          ped_pending_q, ped_pending_d;
  logic [TW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_off_q, flash_off_d;
  logic [TW-1:0] elapsed;
  logic          demand;
  logic [2:0]    main_light;
  logic [2:0]    cross_light;
  logic          walk;

  phase_timer #(.TW(TW)) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .elapsed (elapsed)
  );

  // Next-state logic: actuated greens, fixed yellow/all-red, flash entry only at all-red.
  always_comb begin
    state_d = state_q;
    demand  = bus.cross_sensor | bus.ped_req | ped_pending_q | bus.flash_mode;
    case (state_q)
      ST_MAIN_GREEN: begin
        if (elapsed >= MAIN_MIN_LAST && demand) state_d = ST_MAIN_YELLOW;
      end
      ST_MAIN_YELLOW: begin
        if (elapsed == YELLOW_LAST) state_d = ST_ALL_RED_A;
      end
      ST_ALL_RED_A: begin
        if (elapsed == ALL_RED_LAST) state_d = bus.flash_mode ? ST_FLASH : ST_CROSS_GREEN;
      end
      ST_CROSS_GREEN: begin
        if (elapsed >= CROSS_MIN_LAST &&
            (!bus.cross_sensor || bus.flash_mode || elapsed == CROSS_MAX_LAST)) begin
          state_d = ST_CROSS_YELLOW;
        end
      end
      ST_CROSS_YELLOW: begin
        if (elapsed == YELLOW_LAST) state_d = ST_ALL_RED_B;
      end
      ST_ALL_RED_B: begin
        if (elapsed == ALL_RED_LAST) state_d = bus.flash_mode ? ST_FLASH : ST_MAIN_GREEN;
      end
      ST_FLASH: begin
        if (!bus.flash_mode) state_d = ST_ALL_RED_B;
      end
      default: state_d = ST_MAIN_GREEN;
    endcase
  end

  // Pedestrian latch: a request arriving on or during a cross green is served by it.
  always_comb begin
    ped_pending_d = ped_pending_q | bus.ped_req;
    if (state_q == ST_CROSS_GREEN || state_d == ST_CROSS_GREEN) begin
      ped_pending_d = 1'b0;
    end
  end

  // Flash blinker: lit for FLASH_HALF cycles, dark for FLASH_HALF, restarting lit on entry.
  always_comb begin
    flash_cnt_d = '0;
    flash_off_d = 1'b0;
    if (state_q == ST_FLASH) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_off_d = ~flash_off_q;
      end else begin
        flash_cnt_d = flash_cnt_q + TW'(1);
        flash_off_d = flash_off_q;
      end
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_MAIN_GREEN;
      ped_pending_q <= 1'b0;
      flash_cnt_q   <= '0;
      flash_off_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_off_q   <= flash_off_d;
    end
  end

  // Moore lamp decode; anything not explicitly lit shows red on both roads.
  always_comb begin
    main_light  = LIGHT_R;
    cross_light = LIGHT_R;
    walk        = 1'b0;
    case (state_q)
      ST_MAIN_GREEN:   main_light = LIGHT_G;
      ST_MAIN_YELLOW:  main_light = LIGHT_Y;
      ST_CROSS_GREEN: begin
        cross_light = LIGHT_G;
        walk        = 1'b1;
      end
      ST_CROSS_YELLOW: cross_light = LIGHT_Y;
      ST_FLASH: begin
        main_light  = flash_off_q ? LIGHT_OFF : LIGHT_Y;
        cross_light = flash_off_q ? LIGHT_OFF : LIGHT_R;
      end
      default: ;
    endcase
  end

  assign bus.main_light  = main_light;
  assign bus.cross_light = cross_light;
  assign bus.walk        = walk;
  assign bus.ped_pending = ped_pending_q;
  assign bus.phase       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_actuated.sv
// Bench for the actuated intersection controller: scripted scenario table,
// hand-written reset/pedestrian sequences, and randomized traffic compared
// against a cycle-count model of the phase rules.
module tb_traffic_light_ctrl_actuated;
  import traffic_pkg::*;

  localparam int TW              = 8;
  localparam int MAIN_MIN_GREEN  = 8;
  localparam int CROSS_MIN_GREEN = 4;
  localparam int CROSS_MAX_GREEN = 10;
  localparam int YELLOW_TIME     = 3;
  localparam int ALL_RED_TIME    = 2;
  localparam int FLASH_HALF      = 4;

  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  logic clk = 1'b0;
  logic reset_n;

  traffic_light_ctrl_actuated_if bus_if ();

  traffic_light_ctrl_actuated #(
    .TW              (TW),
    .MAIN_MIN_GREEN  (MAIN_MIN_GREEN),
    .CROSS_MIN_GREEN (CROSS_MIN_GREEN),
    .CROSS_MAX_GREEN (CROSS_MAX_GREEN),
    .YELLOW_TIME     (YELLOW_TIME),
    .ALL_RED_TIME    (ALL_RED_TIME),
    .FLASH_HALF      (FLASH_HALF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Scenario record: inputs held for reps cycles, expected outputs after each edge.
  typedef struct {
    bit         rst_before;
    bit         sensor;
    bit         ped;
    bit         flash;
    int         reps;
    logic [2:0] exp_main;
    logic [2:0] exp_cross;
    bit         exp_walk;
    bit         exp_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit s, bit p, bit f, int n,
                              logic [2:0] m, logic [2:0] c, bit w, bit pd);
    vec_t v;
    v.rst_before = rst;
    v.sensor     = s;
    v.ped        = p;
    v.flash      = f;
    v.reps       = n;
    v.exp_main   = m;
    v.exp_cross  = c;
    v.exp_walk   = w;
    v.exp_pend   = pd;
    return v;
  endfunction

  // Reference model: named phases, time spent in phase as an unbounded count.
  typedef enum int {P_MG, P_MY, P_ARA, P_CG, P_CY, P_ARB, P_FL} mphase_t;
  mphase_t m_ph;
  int      m_t;
  bit      m_pend;

  task automatic model_reset();
    m_ph   = P_MG;
    m_t    = 0;
    m_pend = 1'b0;
  endtask

  task automatic model_step(bit s, bit p, bit f);
    mphase_t nx;
    bit      dem;
    int      served;
    nx     = m_ph;
    dem    = s | p | m_pend | f;
    served = m_t + 1;
    case (m_ph)
      P_MG:  if (served >= MAIN_MIN_GREEN && dem) nx = P_MY;
      P_MY:  if (served == YELLOW_TIME) nx = P_ARA;
      P_ARA: if (served == ALL_RED_TIME) nx = f ? P_FL : P_CG;
      P_CG:  if (served >= CROSS_MIN_GREEN && (!s || f || served == CROSS_MAX_GREEN)) nx = P_CY;
      P_CY:  if (served == YELLOW_TIME) nx = P_ARB;
      P_ARB: if (served == ALL_RED_TIME) nx = f ? P_FL : P_MG;
      P_FL:  if (!f) nx = P_ARB;
      default: nx = P_MG;
    endcase
    if (m_ph == P_CG || nx == P_CG) m_pend = 1'b0;
    else m_pend = m_pend | p;
    m_t  = (nx == m_ph) ? m_t + 1 : 0;
    m_ph = nx;
  endtask

  task automatic model_outputs(output logic [2:0] m, output logic [2:0] c, output bit w);
    bit lit;
    lit = ((m_t / FLASH_HALF) % 2) == 0;
    m = L_R;
    c = L_R;
    w = 1'b0;
    case (m_ph)
      P_MG: m = L_G;
      P_MY: m = L_Y;
      P_CG: begin c = L_G; w = 1'b1; end
      P_CY: c = L_Y;
      P_FL: begin m = lit ? L_Y : L_OFF; c = lit ? L_R : L_OFF; end
      default: ;
    endcase
  endtask

  task automatic check_val(string name, logic [2:0] act, logic [2:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output(string tag, logic [2:0] m, logic [2:0] c, bit w, bit pd);
    check_val({tag, ".main"},  bus_if.main_light,  m);
    check_val({tag, ".cross"}, bus_if.cross_light, c);
    check_val({tag, ".walk"},  {2'b00, bus_if.walk},        {2'b00, w});
    check_val({tag, ".pend"},  {2'b00, bus_if.ped_pending}, {2'b00, pd});
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic apply_stimulus(bit s, bit p, bit f);
    bus_if.cross_sensor = s;
    bus_if.ped_req      = p;
    bus_if.flash_mode   = f;
    @(posedge clk);
    model_step(s, p, f);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n             = 1'b0;
    bus_if.cross_sensor = 1'b0;
    bus_if.ped_req      = 1'b0;
    bus_if.flash_mode   = 1'b0;
    #1;
    check_output("reset", L_G, L_R, 1'b0, 1'b0);
    check_val("reset.phase", bus_if.phase, ST_MAIN_GREEN);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [2:0] em, ec;
    bit         ew;
    bit         rs, rp, rf;

    reset_n             = 1'b0;
    bus_if.cross_sensor = 1'b0;
    bus_if.ped_req      = 1'b0;
    bus_if.flash_mode   = 1'b0;
    model_reset();

    // Cross sensor held from reset: min main green, max cross green, main re-served.
    vecs.push_back(mk(1, 1, 0, 0, 7,  L_G, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3,  L_Y, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2,  L_R, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 10, L_R, L_G, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3,  L_R, L_Y, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2,  L_R, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8,  L_G, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  L_Y, L_R, 0, 0));
    // Pedestrian pulse at edge 20, then a second request ignored during cross green.
    vecs.push_back(mk(1, 0, 0, 0, 20, L_G, L_R, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1,  L_Y, L_R, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_Y, L_R, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_R, L_R, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 4,  L_R, L_G, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3,  L_R, L_Y, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_R, L_R, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 10, L_G, L_R, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1,  L_Y, L_R, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_Y, L_R, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_R, L_R, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1,  L_R, L_G, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1,  L_R, L_G, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_R, L_G, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3,  L_R, L_Y, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_R, L_R, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 15, L_G, L_R, 0, 0));
    // Flash requested during cross green: clearance completes, blink, then exit via all-red.
    vecs.push_back(mk(1, 1, 0, 0, 7,  L_G, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3,  L_Y, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2,  L_R, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  L_R, L_G, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 3,  L_R, L_G, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 3,  L_R, L_Y, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 2,  L_R, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4,  L_Y, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4,  L_OFF, L_OFF, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4,  L_Y, L_R, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 2,  L_OFF, L_OFF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  L_R, L_R, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8,  L_G, L_R, 0, 0));

    repeat (2) @(negedge clk);

    // Idle intersection rests in main green.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_val($sformatf("idle%0d.main", i),  bus_if.main_light,  L_G);
      check_val($sformatf("idle%0d.cross", i), bus_if.cross_light, L_R);
      check_val($sformatf("idle%0d.phase", i), bus_if.phase, ST_MAIN_GREEN);
    end

    $display("[TB] scenario table: %0d records", vecs.size());
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      for (int r = 0; r < vecs[i].reps; r++) begin
        apply_stimulus(vecs[i].sensor, vecs[i].ped, vecs[i].flash);
        check_output($sformatf("vec%0d.%0d", i, r), vecs[i].exp_main,
                     vecs[i].exp_cross, vecs[i].exp_walk, vecs[i].exp_pend);
      end
    end

    // Asynchronous reset in the middle of cross yellow with a request latched.
    do_reset();
    repeat (23) apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("midcy.before", L_R, L_Y, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("midcy.latched", L_R, L_Y, 1'b0, 1'b1);
    bus_if.ped_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midcy.async", L_G, L_R, 1'b0, 1'b0);
    check_val("midcy.phase", bus_if.phase, ST_MAIN_GREEN);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic against the reference model.
    rs = 1'b0;
    rf = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        rs = 1'b0;
        rf = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      if ($urandom_range(0, 199) == 0) rf = ~rf;
      rp = ($urandom_range(0, 24) == 0);
      apply_stimulus(rs, rp, rf);
      model_outputs(em, ec, ew);
      check_output($sformatf("rand%0d", i), em, ec, ew, m_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
